div_sequencer: RTL and testbench

- Multi-cycle signed divide controller for the ALU.
- Accepts one operand pair per start pulse and resolves one quotient bit per clock using a restore-on-negative step.
- Applies sign correction and returns the packed {remainder, quotient} word, which feeds the HI/LO write path.
- Replaces the single-cycle divide array where timing cannot close.

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_step.sv | 28 ++
 rtl/div_sequencer.sv | 154 +++++++++++++++
 tb/tb_div_sequencer.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle signed divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Widest operand the all-ones divide-by-zero pattern is sized for.
  localparam int MAX_DATA_WIDTH = 64;

  localparam logic [2*MAX_DATA_WIDTH-1:0] DIV_ZERO_RESULT = '1;

  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, restore on negative.
module div_step
  import div_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH:0]   rem_in,
  input  logic                  dividend_bit,
  input  logic [DATA_WIDTH-1:0] abs_divisor,
  output logic [DATA_WIDTH:0]   rem_out,
  output logic                  q_bit
);

  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] trial;

  // rem_in[DATA_WIDTH] is always clear after a restore, so only the low bits shift on.
  logic rem_msb_unused;
  assign rem_msb_unused = rem_in[DATA_WIDTH];

  always_comb begin
    shifted = {rem_in[DATA_WIDTH-1:0], dividend_bit};
    trial   = shifted - {1'b0, abs_divisor};
    q_bit   = ~trial[DATA_WIDTH];
    rem_out = q_bit ? trial : (trial + {1'b0, abs_divisor});
  end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle signed divide controller: magnitudes are divided one quotient bit per
// clock, then the quotient is sign-corrected and {remainder, quotient} is published.
//
// state | meaning
// IDLE  | waiting for start; special cases (x/0, 0/y) go straight to DONE
// ITER  | one restoring step per cycle, DATA_WIDTH cycles
// SIGN  | negate quotient if operand signs differ, write result
// DONE  | one-cycle done pulse, then back to IDLE
module div_sequencer
  import div_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [DATA_WIDTH-1:0]   dividend,
  input  logic [DATA_WIDTH-1:0]   divisor,
  output logic                    busy,
  output logic                    done,
  output logic                    div_by_zero,
  output logic [2*DATA_WIDTH-1:0] result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = cnt_width(DATA_WIDTH);

  div_state_e state, state_nxt;

  logic [W-1:0]  abs_dividend;
  logic [W-1:0]  abs_divisor;
  logic [W-1:0]  quo;
  logic [W:0]    rem;
  logic [CW-1:0] count;
  logic          neg_q;

  logic          accept;
  logic          divisor_zero;
  logic          dividend_zero;
  logic [W-1:0]  dividend_mag;
  logic [W-1:0]  divisor_mag;
  logic [W-1:0]  quo_signed;
  logic [W:0]    rem_next;
  logic          q_bit;

  // abort wins over a simultaneous start, so the request is simply dropped.
  assign accept        = (state == IDLE) && start && !abort;
  assign divisor_zero  = (divisor == '0);
  assign dividend_zero = (dividend == '0);

  // Two's-complement magnitude; the most negative value maps onto 2^(W-1) unsigned.
  assign dividend_mag = dividend[W-1] ? -dividend : dividend;
  assign divisor_mag  = divisor[W-1]  ? -divisor  : divisor;
  assign quo_signed   = neg_q ? -quo : quo;

  div_step #(
    .DATA_WIDTH (W)
  ) u_div_step (
    .rem_in       (rem),
    .dividend_bit (abs_dividend[count]),
    .abs_divisor  (abs_divisor),
    .rem_out      (rem_next),
    .q_bit        (q_bit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (divisor_zero || dividend_zero) ? DONE : ITER;
        end
      end
      ITER: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (count == '0) begin
          state_nxt = SIGN;
        end
      end
      SIGN: begin
        busy      = 1'b1;
        state_nxt = abort ? IDLE : DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      abs_dividend <= '0;
      abs_divisor  <= '0;
      quo          <= '0;
      rem          <= '0;
      count        <= '0;
      neg_q        <= 1'b0;
      div_by_zero  <= 1'b0;
      result       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            div_by_zero <= divisor_zero;
            if (divisor_zero) begin
              result <= DIV_ZERO_RESULT[2*W-1:0];
            end else if (dividend_zero) begin
              result <= '0;
            end else begin
              abs_dividend <= dividend_mag;
              abs_divisor  <= divisor_mag;
              neg_q        <= dividend[W-1] ^ divisor[W-1];
              rem          <= '0;
              quo          <= '0;
              count        <= CW'(W - 1);
            end
          end
        end
        ITER: begin
          if (!abort) begin
            rem <= rem_next;
            quo <= {quo[W-2:0], q_bit};
            if (count != '0) begin
              count <= count - CW'(1);
            end
          end
        end
        SIGN: begin
          // Remainder stays an unsigned magnitude; only the quotient carries the sign.
          if (!abort) begin
            result <= {rem[W-1:0], quo_signed};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: scoreboard of expected results, one task per scenario.
module tb_div_sequencer;

  localparam int W     = 32;
  localparam int LIMIT = 200;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [W-1:0]   dividend = '0;
  logic [W-1:0]   divisor = '0;
  logic           busy;
  logic           done;
  logic           div_by_zero;
  logic [2*W-1:0] result;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2*W-1:0] result;
    logic           dbz;
    int             lat;
  } exp_t;

  exp_t sb[$];

  div_sequencer #(.DATA_WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .result      (result)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W-1:0] ma, mb, q, r;
    e.dbz = 1'b0;
    e.lat = W + 2;
    if (b == '0) begin
      e.result = '1;
      e.dbz    = 1'b1;
      e.lat    = 1;
    end else if (a == '0) begin
      e.result = '0;
      e.lat    = 1;
    end else begin
      ma = a[W-1] ? (32'd0 - a) : a;
      mb = b[W-1] ? (32'd0 - b) : b;
      q  = ma / mb;
      r  = ma % mb;
      if (a[W-1] ^ b[W-1]) q = 32'd0 - q;
      e.result = {r, q};
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives a one-cycle start; on return the start edge has been taken (cycle 1).
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit scored);
    if (scored) sb.push_back(model(a, b));
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    step();
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic wait_done(input int from_cycle, output int cycles, output int busy_cycles);
    cycles      = from_cycle;
    busy_cycles = 0;
    while (done !== 1'b1 && cycles < LIMIT) begin
      if (busy === 1'b1) busy_cycles++;
      step();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags: got %b want 000", {busy, done, div_by_zero});
    end
    checks++;
    if (result !== '0) begin
      failures++;
      $display("FAIL reset_result: got %h want 0", result);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int cyc, bc;
    exp_t e;
    issue(32'd100, 32'd7, 1'b1);
    wait_done(1, cyc, bc);
    e = sb.pop_front();
    checks++;
    if (result !== 64'h00000002_0000000E) begin
      failures++;
      $display("FAIL basic_result: got %h want 000000020000000e", result);
    end
    checks++;
    if (result !== e.result) begin
      failures++;
      $display("FAIL basic_model: got %h want %h", result, e.result);
    end
    checks++;
    if (div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL basic_dbz: got %b want 0", div_by_zero);
    end
    checks++;
    if (cyc !== 34) begin
      failures++;
      $display("FAIL basic_latency: got %0d want 34", cyc);
    end
    checks++;
    if (bc !== 33) begin
      failures++;
      $display("FAIL basic_busy_cycles: got %0d want 33", bc);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_pulse: got %b want 0", done);
    end
  endtask

  task automatic test_signed();
    logic [W-1:0]   ta [4] = '{32'hFFFFFF9C, 32'd100, 32'h80000000, 32'h80000000};
    logic [W-1:0]   tb [4] = '{32'd7, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'd1};
    logic [2*W-1:0] tw [4] = '{64'h00000002_FFFFFFF2, 64'h00000002_FFFFFFF2,
                               64'h00000000_80000000, 64'h00000000_80000000};
    int cyc, bc;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      issue(ta[i], tb[i], 1'b1);
      wait_done(1, cyc, bc);
      e = sb.pop_front();
      checks++;
      if (result !== tw[i]) begin
        failures++;
        $display("FAIL signed_%0d_result: got %h want %h", i, result, tw[i]);
      end
      checks++;
      if (cyc !== e.lat || div_by_zero !== e.dbz) begin
        failures++;
        $display("FAIL signed_%0d_lat_dbz: got %0d/%b want %0d/%b", i, cyc, div_by_zero, e.lat, e.dbz);
      end
      step();
    end
  endtask

  task automatic test_special();
    logic [W-1:0]   ta [3] = '{32'd1234, 32'd0, 32'd0};
    logic [W-1:0]   tb [3] = '{32'd0, 32'd5, 32'd0};
    logic [2*W-1:0] tw [3] = '{64'hFFFFFFFF_FFFFFFFF, 64'h0, 64'hFFFFFFFF_FFFFFFFF};
    logic           td [3] = '{1'b1, 1'b0, 1'b1};
    int cyc, bc;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      issue(ta[i], tb[i], 1'b1);
      wait_done(1, cyc, bc);
      e = sb.pop_front();
      checks++;
      if (result !== tw[i] || div_by_zero !== td[i]) begin
        failures++;
        $display("FAIL special_%0d: got %h/%b want %h/%b", i, result, div_by_zero, tw[i], td[i]);
      end
      checks++;
      if (cyc !== 1 || cyc !== e.lat) begin
        failures++;
        $display("FAIL special_%0d_latency: got %0d want 1", i, cyc);
      end
      step();
    end
  endtask

  task automatic test_ignored_start_abort();
    int cyc, bc, seen;
    exp_t e;
    issue(32'd100, 32'd7, 1'b1);
    repeat (8) step();
    dividend = 32'd9;
    divisor  = 32'd3;
    start    = 1'b1;
    step();
    start    = 1'b0;
    wait_done(10, cyc, bc);
    e = sb.pop_front();
    checks++;
    if (result !== 64'h00000002_0000000E || result !== e.result || cyc !== 34) begin
      failures++;
      $display("FAIL ignored_start: got %h at %0d want 000000020000000e at 34", result, cyc);
    end
    step();

    issue(32'd50, 32'd3, 1'b0);
    repeat (18) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle: got busy=%b done=%b want 0 0", busy, done);
    end
    seen = 0;
    repeat (40) begin
      if (done === 1'b1) seen++;
      step();
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL abort_no_done: got %0d pulses want 0", seen);
    end
    checks++;
    if (result !== 64'h00000002_0000000E || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL abort_hold: got %h/%b want 000000020000000e/0", result, div_by_zero);
    end

    dividend = 32'd9;
    divisor  = 32'd3;
    start    = 1'b1;
    abort    = 1'b1;
    step();
    start    = 1'b0;
    abort    = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL start_abort_priority: got busy=%b done=%b want 0 0", busy, done);
    end

    issue(32'd9, 32'd3, 1'b1);
    wait_done(1, cyc, bc);
    e = sb.pop_front();
    checks++;
    if (result !== 64'h00000000_00000003 || result !== e.result) begin
      failures++;
      $display("FAIL after_abort: got %h want 0000000000000003", result);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int cyc, bc, seen;
    exp_t e;
    issue(32'd1234, 32'd0, 1'b1);
    wait_done(1, cyc, bc);
    e = sb.pop_front();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (div_by_zero !== 1'b0 || result !== '0) begin
      failures++;
      $display("FAIL reset_clears_dbz: got %b/%h want 0/0", div_by_zero, result);
    end

    issue(32'd100, 32'd7, 1'b1);
    wait_done(1, cyc, bc);
    e = sb.pop_front();
    checks++;
    if (result !== e.result) begin
      failures++;
      $display("FAIL reset_pre_op: got %h want %h", result, e.result);
    end
    step();
    issue(32'd9, 32'd3, 1'b0);
    repeat (5) step();
    rst_n = 1'b0;
    step();
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || result !== '0) begin
      failures++;
      $display("FAIL reset_mid_iter: got %b/%h want 000/0", {busy, done, div_by_zero}, result);
    end
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      if (done === 1'b1 || busy === 1'b1) seen++;
      step();
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL reset_op_lost: got %0d active cycles want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bc;
    exp_t e;
    issue(32'd15, 32'd4, 1'b1);
    wait_done(1, cyc, bc);
    e = sb.pop_front();
    checks++;
    if (result !== 64'h00000003_00000003 || result !== e.result) begin
      failures++;
      $display("FAIL b2b_first: got %h want 0000000300000003", result);
    end
    step();
    issue(32'hFFFFFFF1, 32'd4, 1'b1);
    wait_done(1, cyc, bc);
    e = sb.pop_front();
    checks++;
    if (result !== 64'h00000003_FFFFFFFD || result !== e.result || cyc !== 34) begin
      failures++;
      $display("FAIL b2b_second: got %h at %0d want 00000003fffffffd at 34", result, cyc);
    end
    step();
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    int cyc, bc;
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      b = (i % 3 == 0) ? W'($urandom_range(1, 20)) : $urandom;
      if (i % 4 == 1) b = -b;
      issue(a, b, 1'b1);
      wait_done(1, cyc, bc);
      e = sb.pop_front();
      checks++;
      if (result !== e.result || div_by_zero !== e.dbz || cyc !== e.lat) begin
        failures++;
        $display("FAIL random_%0d %h/%h: got %h/%b/%0d want %h/%b/%0d",
                 i, a, b, result, div_by_zero, cyc, e.result, e.dbz, e.lat);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_special();
    test_ignored_start_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
